// File: rtl/modsqr_phase_sequencer.sv
// Run controller for the two-die modular squaring datapath: accepts a job of T
// squarings, drives the thermometer clk_phase vector and reports completion.
// Optional watchdog timeout is compiled in with GGG_SEQ_WATCHDOG_EN.
module modsqr_phase_sequencer #(
  parameter int NUM_PHASES     = 16,
  parameter int ITER_W         = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  input  logic [ITER_W-1:0]     cmd_iters,
  output logic                  cmd_ready,
  input  logic                  abort,
  input  logic                  sq_valid,
  output logic                  sq_start,
  output logic [NUM_PHASES-1:0] clk_phase,
  output logic                  busy,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [ITER_W-1:0]     done_iters,
  output logic                  done_err,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid is never withdrawn before the transfer completes.

  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_cnt;
  logic [ITER_W-1:0] iter_cnt;
  logic [ITER_W-1:0] iter_inc;
  logic [ITER_W-1:0] t_q;
  logic              accept;
  logic              count_sq;
  logic              timeout_hit;
  logic              run_active;

  // iter_cnt never exceeds T, so the increment cannot wrap even for T = all ones.
  assign iter_inc = iter_cnt + ITER_W'(1);

`ifdef GGG_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            done_err_q;

  // wd_cnt holds the number of cycles since the last start or counted sq_valid,
  // so the timeout decision lands exactly TIMEOUT_CYCLES cycles after that event.
  assign timeout_hit = (state_q == S_RUN) && !sq_valid &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt     <= '0;
      done_err_q <= 1'b0;
    end else begin
      if (accept) begin
        wd_cnt     <= WD_W'(1);
        done_err_q <= 1'b0;
      end else if (count_sq) begin
        wd_cnt <= WD_W'(1);
      end else if (run_active) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (timeout_hit && !abort) begin
        done_err_q <= 1'b1;
      end
    end
  end

  assign done_err = done_err_q;
`else
  assign timeout_hit = 1'b0;
  assign done_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    count_sq = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = (cmd_iters == '0) ? S_DONE : S_START;
        end
      end
      S_START: begin
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // Abort takes priority over a simultaneous final sq_valid.
        if (abort) begin
          state_d = S_IDLE;
        end else if (sq_valid) begin
          count_sq = 1'b1;
          if (iter_inc == t_q) begin
            state_d = S_DONE;
          end
        end else if (timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign run_active = (state_q == S_START) || (state_q == S_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt <= '0;
      iter_cnt  <= '0;
      t_q       <= '0;
    end else begin
      if (accept) begin
        phase_cnt <= '0;
        iter_cnt  <= '0;
        t_q       <= cmd_iters;
      end else begin
        if (run_active) begin
          phase_cnt <= (phase_cnt == PH_W'(NUM_PHASES - 1)) ? '0 : phase_cnt + PH_W'(1);
        end
        if (count_sq) begin
          iter_cnt <= iter_inc;
        end
      end
    end
  end

  always_comb begin
    clk_phase = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      clk_phase[k] = run_active && (int'(phase_cnt) >= k);
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign sq_start   = (state_q == S_START);
  assign busy       = run_active;
  assign done_valid = (state_q == S_DONE);
  assign done_iters = iter_cnt;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_modsqr_phase_sequencer.sv
// Directed self-checking bench for modsqr_phase_sequencer; watchdog scenario
// runs only when GGG_SEQ_WATCHDOG_EN is defined.
module tb_modsqr_phase_sequencer;

  localparam int W  = 64;
  localparam int NP = 16;
`ifdef GGG_SEQ_WATCHDOG_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic [W-1:0]  cmd_iters;
  logic          cmd_ready;
  logic          abort;
  logic          sq_valid;
  logic          sq_start;
  logic [NP-1:0] clk_phase;
  logic          busy;
  logic          done_valid;
  logic          done_ready;
  logic [W-1:0]  done_iters;
  logic          done_err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  modsqr_phase_sequencer #(
    .NUM_PHASES     (NP),
    .ITER_W         (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_iters  (cmd_iters),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .sq_valid   (sq_valid),
    .sq_start   (sq_start),
    .clk_phase  (clk_phase),
    .busy       (busy),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_iters (done_iters),
    .done_err   (done_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NP-1:0] therm(input int p);
    logic [NP-1:0] v;
    v = '0;
    for (int k = 0; k < NP; k++) v[k] = (p >= k);
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a job in the current cycle and returns one cycle later (rel 1).
  task automatic accept_job(input logic [W-1:0] t, input logic ab);
    cmd_valid = 1'b1;
    cmd_iters = t;
    abort     = ab;
    check("accept_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_iters = {$urandom(), $urandom()};
  endtask

  task automatic finish_done();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("release_done_valid", done_valid, 1'b0);
    check("release_cmd_ready", cmd_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_sq_start"}, sq_start, 1'b0);
    check({tag, "_clk_phase"}, clk_phase, 16'h0000);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done_valid"}, done_valid, 1'b0);
    check({tag, "_done_iters"}, done_iters, 64'd0);
    check({tag, "_done_err"}, done_err, 1'b0);
    check({tag, "_state"}, dbg_state, 2'd0);
  endtask

  logic          flag;
  logic          flag2;
  logic [W-1:0]  max_t;

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_iters  = '0;
    abort      = 1'b0;
    sq_valid   = 1'b0;
    done_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // T=1, sq_valid at rel 20, done at rel 21
    accept_job(64'd1, 1'b0);
    flag = 1'b0;
    for (int r = 1; r <= 20; r++) begin
      check($sformatf("t1_phase_r%0d", r), clk_phase, therm((r - 1) % 16));
      if (r == 1) check("t1_start_r1", sq_start, 1'b1);
      if (r == 2) check("t1_start_r2", sq_start, 1'b0);
      if (r > 2 && sq_start) flag = 1'b1;
      if (done_valid) flag = 1'b1;
      if (r == 20) sq_valid = 1'b1;
      tick();
    end
    sq_valid = 1'b0;
    check("t1_no_stray", flag, 1'b0);
    check("t1_phase_hand17", therm(16), 16'hFFFF);
    check("t1_done_valid", done_valid, 1'b1);
    check("t1_done_iters", done_iters, 64'd1);
    check("t1_done_err", done_err, 1'b0);
    check("t1_done_phase", clk_phase, 16'h0000);
    check("t1_done_busy", busy, 1'b0);
    check("t1_done_cmd_ready", cmd_ready, 1'b0);
    finish_done();

    // T=3 with an extra sq_valid in START
    accept_job(64'd3, 1'b0);
    flag = 1'b0;
    for (int r = 1; r <= 48; r++) begin
      sq_valid = (r == 1) || (r == 16) || (r == 32) || (r == 48);
      if (done_valid) flag = 1'b1;
      if (r == 17) check("t3_phase_wrap", clk_phase, 16'h0001);
      if (r == 16) check("t3_phase_full", clk_phase, 16'hFFFF);
      tick();
    end
    sq_valid = 1'b0;
    check("t3_no_early_done", flag, 1'b0);
    check("t3_done_valid", done_valid, 1'b1);
    check("t3_done_iters", done_iters, 64'd3);
    finish_done();

    // T=0: immediate done, no start pulse
    accept_job(64'd0, 1'b0);
    check("t0_done_valid", done_valid, 1'b1);
    check("t0_sq_start", sq_start, 1'b0);
    check("t0_busy", busy, 1'b0);
    check("t0_done_iters", done_iters, 64'd0);
    check("t0_done_err", done_err, 1'b0);
    finish_done();

    // T=5, abort together with the second sq_valid
    accept_job(64'd5, 1'b0);
    for (int r = 1; r <= 6; r++) begin
      sq_valid = (r == 3) || (r == 6);
      abort    = (r == 6);
      tick();
    end
    sq_valid = 1'b0;
    abort    = 1'b0;
    check("ab_cmd_ready", cmd_ready, 1'b1);
    check("ab_busy", busy, 1'b0);
    check("ab_clk_phase", clk_phase, 16'h0000);
    check("ab_sq_start", sq_start, 1'b0);
    flag = 1'b0;
    for (int r = 0; r < 5; r++) begin
      if (done_valid) flag = 1'b1;
      tick();
    end
    check("ab_no_done", flag, 1'b0);

    // T=2 accepted with abort high in IDLE (ignored), completes normally
    accept_job(64'd2, 1'b1);
    check("t2_sq_start", sq_start, 1'b1);
    tick();
    sq_valid = 1'b1;
    tick();
    tick();
    sq_valid = 1'b0;
    check("t2_done_valid", done_valid, 1'b1);
    check("t2_done_iters", done_iters, 64'd2);
    finish_done();

    // Backpressure on done, abort/sq_valid ignored in DONE
    accept_job(64'd1, 1'b0);
    tick();
    sq_valid = 1'b1;
    tick();
    sq_valid = 1'b0;
    check("bp_done_valid", done_valid, 1'b1);
    flag  = 1'b0;
    flag2 = 1'b0;
    for (int r = 0; r < 10; r++) begin
      abort    = (r == 3);
      sq_valid = (r == 5) || (r == 6);
      if (!done_valid || cmd_ready || busy) flag = 1'b1;
      if (done_iters != 64'd1) flag2 = 1'b1;
      tick();
    end
    abort    = 1'b0;
    sq_valid = 1'b0;
    check("bp_held_valid", flag, 1'b0);
    check("bp_held_iters", flag2, 1'b0);
    check("bp_iters_end", done_iters, 64'd1);
    finish_done();

    // Back-to-back job, then asynchronous reset mid-run
    accept_job(64'd4, 1'b0);
    tick();
    sq_valid = 1'b1;
    tick();
    sq_valid = 1'b0;
    tick();
    check("rst_busy_before", busy, 1'b1);
    check("rst_iters_before", done_iters, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    reset_n = 1'b1;
    tick();
    check("after_rst_ready", cmd_ready, 1'b1);

    // Maximum T: no premature completion, then abort
    max_t = '1;
    accept_job(max_t, 1'b0);
    tick();
    sq_valid = 1'b1;
    tick();
    tick();
    sq_valid = 1'b0;
    check("tmax_no_done", done_valid, 1'b0);
    check("tmax_busy", busy, 1'b1);
    check("tmax_iters", done_iters, 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("tmax_abort_idle", cmd_ready, 1'b1);

`ifdef GGG_SEQ_WATCHDOG_EN
    // Watchdog: T=4, single sq_valid at rel 2, done 64 cycles later
    accept_job(64'd4, 1'b0);
    tick();
    sq_valid = 1'b1;
    tick();
    sq_valid = 1'b0;
    flag = 1'b0;
    for (int r = 3; r < 66; r++) begin
      if (done_valid) flag = 1'b1;
      tick();
    end
    check("wd_no_early", flag, 1'b0);
    check("wd_done_valid", done_valid, 1'b1);
    check("wd_done_err", done_err, 1'b1);
    check("wd_done_iters", done_iters, 64'd1);
    finish_done();
    accept_job(64'd0, 1'b0);
    check("wd_err_cleared", done_err, 1'b0);
    finish_done();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modsqr_phase_sequencer.md
# modsqr_phase_sequencer

Run controller for the two-die modular squaring datapath. Accepts a squaring job (iteration count T) from the host side and pulses the datapath `start`. Generates the 16-bit `clk_phase` vector consumed by the top and mid dies, and counts datapath `valid` pulses until T squarings complete. Reports completion through a held done handshake, with optional watchdog error reporting.

## Interface
Parameters:
- `NUM_PHASES`, 16: width of `clk_phase`; phase counter wraps at NUM_PHASES-1.
- `ITER_W`, 64: width of the iteration count and counters.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in cycles (used only with the watchdog macro).

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `cmd_valid`, in, 1: job request.
- `cmd_iters`, in, ITER_W: T, the number of squarings requested.
- `cmd_ready`, out, 1: high only in IDLE.
- `abort`, in, 1: synchronous cancel of the current job.
- `sq_valid`, in, 1: datapath result-valid pulse, one per completed squaring.
- `sq_start`, out, 1: one-cycle datapath start pulse.
- `clk_phase`, out, NUM_PHASES: thermometer phase vector to the datapath.
- `busy`, out, 1: high in START or RUN.
- `done_valid`, out, 1: job finished; held until accepted.
- `done_ready`, in, 1: host accepts the done report.
- `done_iters`, out, ITER_W: squarings actually completed.
- `done_err`, out, 1: job ended by watchdog timeout.

## Operation
- States and transitions:
  - IDLE → START when `cmd_valid & cmd_ready`, with T≥1.
  - IDLE → DONE when T=0; no `sq_start` is issued and `done_iters`=0.
  - START → RUN after exactly one cycle.
  - RUN → DONE when `sq_valid` brings `iter_cnt` to T.
  - DONE → IDLE when `done_ready`.
  - `abort` in START or RUN → IDLE; no done report is produced.
- `abort` is ignored in IDLE and DONE.
- T is latched on acceptance. `cmd_iters` is don't-care afterwards.
- `sq_start` is 1 only in START.
- `phase_cnt` is cleared to 0 on START entry. It increments every cycle in START and RUN, and wraps from NUM_PHASES-1 to 0.
- `clk_phase[k]` = (`phase_cnt` ≥ k) in START and RUN, else all zero.
  - Bit 0 is 1 throughout the run.
  - Bit 8 is a 50% duty signal.
- `sq_valid` is counted only in RUN. It is ignored in IDLE, START and DONE.
- `iter_cnt` clears on acceptance.
- `done_iters` = `iter_cnt`, and is stable while `done_valid` is high.
- Simultaneous `abort` and final `sq_valid`: abort wins. The state goes to IDLE and there is no done report.
- Counters are ITER_W bits. T = 2^ITER_W−1 must complete without overflow.

## Timing
- Reset values:
  - state IDLE, `cmd_ready`=1.
  - `sq_start`=0, `clk_phase`=0, `busy`=0.
  - `done_valid`=0, `done_iters`=0, `done_err`=0.
- Acceptance in cycle N → cycle N+1: `sq_start`=1, `clk_phase`=16'h0001.
- Cycle N+2: `clk_phase`=16'h0003.
- Cycle N+16: `clk_phase`=16'hFFFF.
- Cycle N+17: `clk_phase`=16'h0001 (wrap).
- Final `sq_valid` in cycle M → `done_valid`=1 in M+1 and `clk_phase`=0 in M+1.
- `done_valid` falls the cycle after `done_valid & done_ready`.
- `cmd_ready` rises in that same cycle, so back-to-back jobs are possible with no idle gap beyond one cycle.
- Abort in cycle A → state IDLE in A+1, with `sq_start`=0 and `clk_phase`=0.
- Mid-operation reset clears all state immediately (asynchronously), and outputs take their reset values.

## Configuration
- `GGG_SEQ_WATCHDOG_EN` defined:
  - A cycle counter clears on START entry and on every counted `sq_valid`.
  - When it reaches TIMEOUT_CYCLES in RUN, the state goes to DONE with `done_err`=1 and `done_iters` equal to the squarings completed.
  - `done_err` clears on the next acceptance.
- Not defined: no watchdog logic; `done_err` is tied 0 and RUN waits indefinitely.

## Test plan
- T=1, `sq_valid` pulsed at N+20 → `sq_start` at N+1 only, `clk_phase` sequence 0001,0003,… from N+1; `done_valid` at N+21, `done_iters`=1, `done_err`=0.
- T=3, `sq_valid` every 16 cycles, with an extra `sq_valid` injected in START → the START pulse is not counted; done follows the third RUN pulse, `done_iters`=3.
- T=0 → `done_valid` the cycle after acceptance, `sq_start` never asserted, `done_iters`=0.
- T=5, `abort` asserted together with the 2nd `sq_valid` → IDLE next cycle, `clk_phase`=0, no `done_valid`; a new T=2 job is then accepted and completes normally.
- Done backpressure: `done_ready` held low 10 cycles → `done_valid`, `done_iters` and `cmd_ready`=0 all stable; release → IDLE one cycle later. Repeat with `reset_n` pulsed low mid-run → all outputs return to their reset values immediately.
- With `GGG_SEQ_WATCHDOG_EN`, TIMEOUT_CYCLES=64, T=4, a single `sq_valid` only → `done_valid` with `done_err`=1 and `done_iters`=1, 64 cycles after that `sq_valid`.
